pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage MIPS pipeline. Combines the ID-stage

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 8 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared state encoding for the pipeline stall/flush scheduler
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating up-counter for performance statistics
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Holds at all-ones so the display never shows a wrapped count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler with halt-drain-resume FSM for the 5-stage pipeline
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             id_jump,
    input  logic             ex_br_taken,
    input  logic             ex_halt,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYC - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_nxt;

    logic pc_c;
    logic ifid_en_c;
    logic ifid_flush_c;
    logic idex_flush_c;
    logic exmem_c;
    logic halted_c;
    logic cycle_inc;
    logic stall_inc;
    logic flush_inc;

    always_comb begin
        state_nxt    = state;
        drain_nxt    = drain_cnt;
        pc_c         = 1'b0;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        exmem_c      = 1'b0;
        halted_c     = 1'b0;
        cycle_inc    = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (state)
            ST_RUN: begin
                cycle_inc = 1'b1;
                exmem_c   = 1'b1;
                if (ex_halt) begin
                    idex_flush_c = 1'b1;
                    state_nxt    = ST_DRAIN;
                    drain_nxt    = '0;
                end else if (ex_br_taken) begin
                    // Redirect squashes both younger instrs, including any pending stall or jump.
                    pc_c         = 1'b1;
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    flush_inc    = 1'b1;
                end else if (load_use) begin
                    // A jr in ID may read the loaded register, so the jump waits a cycle.
                    idex_flush_c = 1'b1;
                    stall_inc    = 1'b1;
                end else if (id_jump) begin
                    pc_c         = 1'b1;
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    flush_inc    = 1'b1;
                end else begin
                    pc_c      = 1'b1;
                    ifid_en_c = 1'b1;
                end
            end
            ST_DRAIN: begin
                cycle_inc    = 1'b1;
                exmem_c      = 1'b1;
                idex_flush_c = 1'b1;
                drain_nxt    = drain_cnt + 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = ST_HALTED;
                    drain_nxt = '0;
                end
            end
            ST_HALTED: begin
                halted_c = 1'b1;
                if (go) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                drain_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    assign pc_en      = rst_n & pc_c;
    assign ifid_en    = rst_n & ifid_en_c;
    assign ifid_flush = rst_n & ifid_flush_c;
    assign idex_flush = rst_n & idex_flush_c;
    assign exmem_en   = rst_n & exmem_c;
    assign halted     = rst_n & halted_c;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cycle_inc),
        .q     (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_en;
        logic halted;
    } ctl_t;

    localparam ctl_t C_RST  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctl_t C_RUN  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctl_t C_STL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam ctl_t C_BR   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctl_t C_JMP  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctl_t C_HLT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use = 1'b0;
    logic id_jump = 1'b0;
    logic ex_br_taken = 1'b0;
    logic ex_halt = 1'b0;
    logic go = 1'b0;
    logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, halted;
    logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

    ctl_t exp_q[$];
    logic [CW-1:0] m_cycle, m_stall, m_flush;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CW), .DRAIN_CYC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_use    (load_use),
        .id_jump     (id_jump),
        .ex_br_taken (ex_br_taken),
        .ex_halt     (ex_halt),
        .go          (go),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag);
        ctl_t got;
        ctl_t e;
        got = '{pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, halted};
        e = exp_q.pop_front();
        check({tag, "_ctl"}, 8'(got), 8'(e));
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_cycle"}, 8'(cycle_cnt), 8'(m_cycle));
        check({tag, "_stall"}, 8'(stall_cnt), 8'(m_stall));
        check({tag, "_flush"}, 8'(flush_cnt), 8'(m_flush));
    endtask

    // Starts and ends just after a negedge with reset released.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        {load_use, id_jump, ex_br_taken, ex_halt, go} = '0;
        m_cycle = '0;
        m_stall = '0;
        m_flush = '0;
        exp_q.push_back(C_RST);
        #1;
        check_ctl(tag);
        check_cnt(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic lu, input logic jmp, input logic br, input logic hlt,
                        input logic g, input ctl_t exp, input bit st, input bit fl,
                        input string tag);
        {load_use, id_jump, ex_br_taken, ex_halt, go} = {lu, jmp, br, hlt, g};
        exp_q.push_back(exp);
        if (!exp.halted) m_cycle = sat(m_cycle);
        if (st) m_stall = sat(m_stall);
        if (fl) m_flush = sat(m_flush);
        #1;
        check_ctl(tag);
        @(posedge clk);
        #1;
        check_cnt(tag);
        @(negedge clk);
        {load_use, id_jump, ex_br_taken, ex_halt, go} = '0;
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset");
        step(0, 0, 0, 0, 0, C_RUN, 0, 0, "idle");
        step(1, 0, 0, 0, 0, C_STL, 1, 0, "load_use");
        step(0, 0, 0, 0, 0, C_RUN, 0, 0, "after_stall");
        step(0, 0, 1, 0, 0, C_BR,  0, 1, "br_alone");
        step(0, 0, 0, 0, 1, C_RUN, 0, 0, "go_in_run");

        do_reset("reset_br");
        step(1, 1, 1, 0, 0, C_BR,  0, 1, "br_over_lu_jmp");

        do_reset("reset_jmp");
        step(1, 1, 0, 0, 0, C_STL, 1, 0, "lu_with_jmp");
        step(0, 1, 0, 0, 0, C_JMP, 0, 1, "jmp_retry");

        do_reset("reset_halt");
        step(0, 0, 1, 1, 0, C_STL, 0, 0, "halt_over_br");
        step(0, 1, 0, 0, 0, C_STL, 0, 0, "drain1");
        step(1, 0, 1, 0, 1, C_STL, 0, 0, "drain2");
        step(0, 0, 0, 0, 0, C_HLT, 0, 0, "halted1");
        step(1, 0, 0, 0, 0, C_HLT, 0, 0, "halted_lu");
        step(0, 0, 0, 0, 1, C_HLT, 0, 0, "go_pulse");
        step(0, 0, 0, 0, 0, C_RUN, 0, 0, "resumed");

        do_reset("reset_sat");
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0, C_STL, 1, 0, "sat_stall");
        end
        check("stall_saturated", 8'(stall_cnt), 8'(CMAX));
        step(0, 0, 0, 1, 0, C_STL, 0, 0, "sat_halt");
        step(0, 0, 0, 0, 0, C_STL, 0, 0, "sat_drain1");
        step(0, 0, 0, 0, 0, C_STL, 0, 0, "sat_drain2");
        step(0, 0, 0, 0, 0, C_HLT, 0, 0, "sat_halted");
        do_reset("reset_in_halted");
        step(0, 0, 0, 0, 0, C_RUN, 0, 0, "run_after_halt_reset");

        step(0, 0, 0, 1, 0, C_STL, 0, 0, "mid_halt");
        step(0, 0, 0, 0, 0, C_STL, 0, 0, "mid_drain");
        do_reset("reset_in_drain");
        step(0, 0, 0, 0, 0, C_RUN, 0, 0, "run_after_drain_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
